// File: rtl/sevenseg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: settles each
// digit, decodes the glyph back to a hex nibble and emits complete 16-bit frames.
module sevenseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [7:0]  anodes,
  output logic [15:0] HEX_out,
  output logic        valid,
  output logic        seg_err
);

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next, cnt_inc;
  logic [14:0] sync1_reg, sync2_reg, prev_reg;
  logic [3:0]  mask_reg, mask_next;
  logic [3:0]  slot_reg [4];
  logic [3:0]  slot_we;
  logic [15:0] slots_flat;
  logic [15:0] hex_reg;
  logic        valid_reg, seg_err_reg;

  logic        legal, known, changed, restart, act, capture, frame_done;
  logic [1:0]  digit_idx;
  logic [3:0]  nibble;
  logic [6:0]  pattern;

  // {anodes, segments} sampled twice; reset to the idle (all-dark) bus value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
      prev_reg  <= '1;
    end else begin
      sync1_reg <= {anodes, segments};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  always_comb begin
    legal     = 1'b0;
    digit_idx = 2'd0;
    if (sync2_reg[14:11] == 4'hF) begin
      case (sync2_reg[10:7])
        4'b1110: begin legal = 1'b1; digit_idx = 2'd0; end
        4'b1101: begin legal = 1'b1; digit_idx = 2'd1; end
        4'b1011: begin legal = 1'b1; digit_idx = 2'd2; end
        4'b0111: begin legal = 1'b1; digit_idx = 2'd3; end
        default: begin legal = 1'b0; digit_idx = 2'd0; end
      endcase
    end
  end

  assign pattern = ~sync2_reg[6:0];

  always_comb begin
    known  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: known = 1'b0;
    endcase
  end

  assign changed = (sync2_reg != prev_reg);
  assign cnt_inc = cnt_reg + 8'd1;
  // WAIT only persists while the bus is illegal, so it re-evaluates every cycle.
  assign restart = (state_reg == ST_WAIT) || changed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_WAIT;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    act        = 1'b0;
    if (restart) begin
      if (legal) begin
        cnt_next = 8'd1;
        if (SETTLE_MAX <= 8'd1) begin
          act        = 1'b1;
          state_next = ST_HOLD;
        end else begin
          state_next = ST_SETTLE;
        end
      end else begin
        cnt_next   = 8'd0;
        state_next = ST_WAIT;
      end
    end else if (state_reg == ST_SETTLE) begin
      cnt_next = cnt_inc;
      if (cnt_inc >= SETTLE_MAX) begin
        act        = 1'b1;
        state_next = ST_HOLD;
      end
    end
  end

  assign capture    = act && known;
  assign frame_done = (mask_reg == 4'hF);

  // A capture landing on the completion edge survives into the next frame's mask.
  always_comb begin
    mask_next = frame_done ? 4'h0 : mask_reg;
    if (capture) begin
      mask_next[digit_idx] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_we[gi]              = capture && (digit_idx == 2'(gi));
      assign slots_flat[4*gi +: 4]    = slot_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        slot_reg[i] <= 4'h0;
      end
      mask_reg    <= 4'h0;
      hex_reg     <= 16'h0000;
      valid_reg   <= 1'b0;
      seg_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (slot_we[i]) begin
          slot_reg[i] <= nibble;
        end
      end
      mask_reg    <= mask_next;
      valid_reg   <= frame_done;
      seg_err_reg <= act && !known;
      if (frame_done) begin
        hex_reg <= slots_flat;
      end
    end
  end

  assign HEX_out = hex_reg;
  assign valid   = valid_reg;
  assign seg_err = seg_err_reg;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: expected frames are queued as stimulus
// is driven and popped when the DUT pulses valid.
module tb_sevenseg_scan_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        rst1;
  logic [6:0]  segments;
  logic [7:0]  anodes;
  logic [15:0] hex4, hex1;
  logic        valid4, valid1, err4, err1;

  int checks = 0;
  int failures = 0;
  int valid4_cnt = 0, err4_cnt = 0, valid1_cnt = 0, err1_cnt = 0;
  logic [15:0] exp_q4[$];
  logic [15:0] exp_q1[$];
  logic [15:0] last_hex4 = 16'h0, last_hex1 = 16'h0;
  bit mon1_en = 1'b0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clock = ~clock;

  sevenseg_scan_decoder #(.SETTLE_CYCLES(4)) u_dut4 (
    .clock(clock), .reset(reset), .segments(segments), .anodes(anodes),
    .HEX_out(hex4), .valid(valid4), .seg_err(err4)
  );

  sevenseg_scan_decoder #(.SETTLE_CYCLES(1)) u_dut1 (
    .clock(clock), .reset(rst1), .segments(segments), .anodes(anodes),
    .HEX_out(hex1), .valid(valid1), .seg_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: pop an expected frame on every valid pulse.
  always @(negedge clock) begin
    if (!reset) begin
      last_hex4 = 16'h0;
    end else begin
      if (err4 === 1'b1) err4_cnt++;
      if (valid4 === 1'b1) begin
        valid4_cnt++;
        if (exp_q4.size() == 0) check("unexpected_valid4", 32'(valid4), 32'd0);
        else check("frame_hex4", 32'(hex4), 32'(exp_q4.pop_front()));
        last_hex4 = hex4;
        $display("tb: dut4 frame HEX_out=%04h", hex4);
      end else begin
        check("hex4_stable", 32'(hex4), 32'(last_hex4));
      end
    end
    if (!rst1 || !mon1_en) begin
      last_hex1 = 16'h0;
    end else begin
      if (err1 === 1'b1) err1_cnt++;
      if (valid1 === 1'b1) begin
        valid1_cnt++;
        if (exp_q1.size() == 0) check("unexpected_valid1", 32'(valid1), 32'd0);
        else check("frame_hex1", 32'(hex1), 32'(exp_q1.pop_front()));
        last_hex1 = hex1;
        $display("tb: dut1 frame HEX_out=%04h", hex1);
      end
    end
  end

  task automatic drive(input int k, input logic [6:0] pat, input int cycles);
    anodes   = {4'hF, 4'(~(4'b0001 << k))};
    segments = ~pat;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic raw(input logic [7:0] an, input logic [6:0] pat, input int cycles);
    anodes   = an;
    segments = ~pat;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic idle(input int cycles);
    anodes   = 8'hFF;
    segments = 7'h7F;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic drain4(input int budget);
    for (int i = 0; i < budget && exp_q4.size() != 0; i++) @(negedge clock);
    check("drain4", 32'(exp_q4.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    rst1  = 1'b0;
    idle(3);
    check("reset_hex", 32'(hex4), 32'h0);
    check("reset_valid", 32'(valid4), 32'h0);
    check("reset_seg_err", 32'(err4), 32'h0);
    reset = 1'b1;
    idle(4);

    // Basic frame
    drive(0, glyph[4], 10);
    drive(1, glyph[3], 10);
    drive(2, glyph[2], 10);
    exp_q4.push_back(16'h1234);
    drive(3, glyph[1], 10);
    idle(6);
    drain4(20);
    check("basic_valid_cnt", 32'(valid4_cnt), 32'd1);
    check("basic_err_cnt", 32'(err4_cnt), 32'd0);

    // Out-of-order scan with overwrite of digit 2
    drive(2, glyph[10], 10);
    drive(0, glyph[15], 10);
    drive(2, glyph[11], 10);
    drive(3, glyph[12], 10);
    check("ooo_no_early_valid", 32'(valid4_cnt), 32'd1);
    exp_q4.push_back(16'hCB0F);
    drive(1, glyph[0], 10);
    idle(6);
    drain4(20);
    check("ooo_valid_cnt", 32'(valid4_cnt), 32'd2);

    // Glitch on the final digit must not complete the frame
    drive(0, glyph[9], 10);
    drive(2, glyph[6], 10);
    drive(3, glyph[8], 10);
    exp_q4.push_back(16'h8659);
    drive(1, glyph[7], 3);
    check("glitch_no_valid", 32'(valid4_cnt), 32'd2);
    drive(1, glyph[5], 10);
    idle(6);
    drain4(20);
    check("glitch_valid_cnt", 32'(valid4_cnt), 32'd3);
    check("glitch_err_cnt", 32'(err4_cnt), 32'd0);

    // Illegal anode patterns between legal captures
    drive(0, glyph[1], 10);
    drive(1, glyph[2], 10);
    raw(8'hF3, glyph[13], 20);
    raw(8'h7E, glyph[14], 20);
    check("illegal_no_valid", 32'(valid4_cnt), 32'd3);
    drive(2, glyph[3], 10);
    exp_q4.push_back(16'h4321);
    drive(3, glyph[4], 10);
    idle(6);
    drain4(20);
    check("illegal_valid_cnt", 32'(valid4_cnt), 32'd4);
    check("illegal_err_cnt", 32'(err4_cnt), 32'd0);

    // Blank glyph on digit 0: one error pulse, slot not marked
    raw(8'hFE, 7'h00, 20);
    check("unknown_err_cnt", 32'(err4_cnt), 32'd1);
    drive(1, glyph[10], 10);
    drive(2, glyph[11], 10);
    drive(3, glyph[12], 10);
    idle(10);
    check("unknown_mask0_clear", 32'(valid4_cnt), 32'd4);
    exp_q4.push_back(16'hCBAD);
    drive(0, glyph[13], 10);
    idle(6);
    drain4(20);
    check("unknown_valid_cnt", 32'(valid4_cnt), 32'd5);
    check("unknown_err_total", 32'(err4_cnt), 32'd1);

    // Reset mid-frame discards the partial mask
    drive(0, glyph[5], 10);
    drive(1, glyph[6], 10);
    drive(2, glyph[7], 10);
    idle(2);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    drive(3, glyph[8], 10);
    idle(10);
    check("midreset_hex", 32'(hex4), 32'h0);
    check("midreset_valid_cnt", 32'(valid4_cnt), 32'd5);

    // SETTLE_CYCLES=1: single-cycle digits are captured; the 4-cycle unit ignores them
    rst1    = 1'b1;
    mon1_en = 1'b1;
    idle(3);
    exp_q1.push_back(16'h7891);
    drive(0, glyph[1], 1);
    drive(1, glyph[9], 1);
    drive(2, glyph[8], 1);
    drive(3, glyph[7], 1);
    idle(6);
    for (int i = 0; i < 20 && exp_q1.size() != 0; i++) @(negedge clock);
    check("settle1_drain", 32'(exp_q1.size()), 32'd0);
    check("settle1_valid_cnt", 32'(valid1_cnt), 32'd1);
    check("settle1_err_cnt", 32'(err1_cnt), 32'd0);
    check("settle4_ignores_short", 32'(valid4_cnt), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
